// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl -- IEEE 1149.1 TAP controller with 4-bit IR, bypass and optional IDCODE register.
//
// Optional feature macro: JTAG_TAP_IDCODE_EN
//   defined   : 32-bit IDCODE register present, opcode 4'b0010 selects it, reset instruction IDCODE
//   undefined : no IDCODE register, 4'b0010 decodes as BYPASS, reset instruction BYPASS
//
// Ports
//   tck_i                   test clock, all state changes on its rising edge
//   trst_i                  synchronous active-high reset into Test-Logic-Reset
//   tms_i                   test mode select
//   tdi_i                   serial test data in
//   tdo_o / tdo_oe_o        serial test data out and its drive enable (ShDR / ShIR only)
//   test_logic_reset_o      high in Test-Logic-Reset
//   capture/shift/pause/update_dr_o   high in the same-named DR state
//   extest/sample_preload/mbist/debug_select_o   decoded from the active instruction
//   bs_chain_tdo_i, debug_tdo_i, mbist_tdo_i     serial returns of the external DR chains
module jtag_tap_ctrl #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1180_0001
) (
    input  logic tck_i,
    input  logic trst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    output logic debug_select_o,
    input  logic bs_chain_tdo_i,
    input  logic debug_tdo_i,
    input  logic mbist_tdo_i
);

    typedef enum logic [3:0] {
        StTlr, StRti,
        StSelDr, StCapDr, StShDr, StEx1Dr, StPauDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPauIr, StEx2Ir, StUpdIr
    } state_e;

    localparam logic [3:0] OpExtest  = 4'b0000;
    localparam logic [3:0] OpSample  = 4'b0001;
    localparam logic [3:0] OpDebug   = 4'b1000;
    localparam logic [3:0] OpMbist   = 4'b1001;
    localparam logic [3:0] IrCapture = 4'b0001;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [3:0] OpIdcode  = 4'b0010;
    localparam logic [3:0] IrReset   = OpIdcode;
`else
    localparam logic [3:0] IrReset   = 4'b1111;
`endif

    state_e     state_q, state_d;
    logic [3:0] ir_q, ir_d;
    logic [3:0] ir_sh_q, ir_sh_d;
    logic       bypass_q, bypass_d;
    logic       sel_extest, sel_sample, sel_debug, sel_mbist, sel_idcode, sel_bypass;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;
`endif

    // TMS-driven next state; trst_i is applied in the register process.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StTlr:   state_d = tms_i ? StTlr   : StRti;
            StRti:   state_d = tms_i ? StSelDr : StRti;
            StSelDr: state_d = tms_i ? StSelIr : StCapDr;
            StCapDr: state_d = tms_i ? StEx1Dr : StShDr;
            StShDr:  state_d = tms_i ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms_i ? StUpdDr : StPauDr;
            StPauDr: state_d = tms_i ? StEx2Dr : StPauDr;
            StEx2Dr: state_d = tms_i ? StUpdDr : StShDr;
            StUpdDr: state_d = tms_i ? StSelDr : StRti;
            StSelIr: state_d = tms_i ? StTlr   : StCapIr;
            StCapIr: state_d = tms_i ? StEx1Ir : StShIr;
            StShIr:  state_d = tms_i ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms_i ? StUpdIr : StPauIr;
            StPauIr: state_d = tms_i ? StEx2Ir : StPauIr;
            StEx2Ir: state_d = tms_i ? StUpdIr : StShIr;
            StUpdIr: state_d = tms_i ? StSelDr : StRti;
            default: state_d = StTlr;
        endcase
    end

    // Instruction decode; unlisted opcodes fall through to BYPASS.
    always_comb begin
        sel_extest = (ir_q == OpExtest);
        sel_sample = (ir_q == OpSample);
        sel_debug  = (ir_q == OpDebug);
        sel_mbist  = (ir_q == OpMbist);
`ifdef JTAG_TAP_IDCODE_EN
        sel_idcode = (ir_q == OpIdcode);
`else
        sel_idcode = 1'b0;
`endif
        sel_bypass = !(sel_extest || sel_sample || sel_debug || sel_mbist || sel_idcode);
    end

    // Register next-state. Entering TLR through TMS clears/resets on the same edge as the
    // state change so the selects never show a stale instruction while in TLR.
    always_comb begin
        ir_d     = ir_q;
        ir_sh_d  = ir_sh_q;
        bypass_d = bypass_q;
`ifdef JTAG_TAP_IDCODE_EN
        idcode_d = idcode_q;
`endif
        if (state_d == StTlr) begin
            ir_d     = IrReset;
            ir_sh_d  = 4'b0000;
            bypass_d = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_d = 32'h0;
`endif
        end else begin
            case (state_q)
                StCapIr: ir_sh_d = IrCapture;
                StShIr:  ir_sh_d = {tdi_i, ir_sh_q[3:1]};
                StUpdIr: ir_d    = ir_sh_q;
                StCapDr: begin
                    if (sel_bypass) bypass_d = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
                    if (sel_idcode) idcode_d = {IDCODE_VALUE[31:1], 1'b1};
`endif
                end
                StShDr: begin
                    if (sel_bypass) bypass_d = tdi_i;
`ifdef JTAG_TAP_IDCODE_EN
                    if (sel_idcode) idcode_d = {tdi_i, idcode_q[31:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_q  <= StTlr;
            ir_q     <= IrReset;
            ir_sh_q  <= 4'b0000;
            bypass_q <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_q <= 32'h0;
`endif
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sh_q  <= ir_sh_d;
            bypass_q <= bypass_d;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_q <= idcode_d;
`endif
        end
    end

    // Serial output mux.
    always_comb begin
        tdo_o = 1'b0;
        if (state_q == StShIr) begin
            tdo_o = ir_sh_q[0];
        end else if (state_q == StShDr) begin
            if (sel_extest || sel_sample) tdo_o = bs_chain_tdo_i;
            else if (sel_debug)           tdo_o = debug_tdo_i;
            else if (sel_mbist)           tdo_o = mbist_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
            else if (sel_idcode)          tdo_o = idcode_q[0];
`endif
            else                          tdo_o = bypass_q;
        end
    end

    assign tdo_oe_o                = (state_q == StShDr) || (state_q == StShIr);
    assign test_logic_reset_o      = (state_q == StTlr);
    assign capture_dr_o            = (state_q == StCapDr);
    assign shift_dr_o              = (state_q == StShDr);
    assign pause_dr_o              = (state_q == StPauDr);
    assign update_dr_o             = (state_q == StUpdDr);
    assign extest_select_o         = sel_extest;
    assign sample_preload_select_o = sel_sample;
    assign mbist_select_o          = sel_mbist;
    assign debug_select_o          = sel_debug;

endmodule
